// File: rtl/fir_requant_decim.sv
// fir_requant_decim
//   Output stage behind the 3-tap FIR. It rescales the 16-bit signed filter
//   result to 8-bit signed using round-half-up, an arithmetic right shift and
//   saturation. It keeps 1 of every DECIM valid samples and buffers the kept
//   samples in a small first-word-fall-through FIFO with a valid/ready output.
//   Saturation and overflow events are reported as sticky flags.
//
// Ports
//   clk          clock, all state on the rising edge
//   reset        asynchronous, active-high, clears all state
//   in_valid     in_data is valid this cycle
//   in_data      16-bit signed FIR result
//   out_ready    consumer accepts out_data this cycle
//   out_valid    FIFO non-empty
//   out_data     8-bit signed FIFO head (first-word-fall-through)
//   level        FIFO occupancy, 0..DEPTH
//   sat_flag     sticky: a sample written to the FIFO had been saturated
//   ovf_flag     sticky: a kept sample was dropped because the FIFO was full
//   clear_flags  synchronous clear of both flags; a same-cycle set event wins
module fir_requant_decim #(
  parameter int SHIFT = 2,
  parameter int DECIM = 2,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [15:0]       in_data,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [7:0]               out_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     sat_flag,
  output logic                     ovf_flag,
  input  logic                     clear_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  // Half an LSB of the output scale; zero when no shift is applied.
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [16:0] RND = (SHIFT > 0) ? 17'(1 << RND_SH) : 17'sd0;

  // ---------------------------------------------------------------------------
  // Requantise
  // ---------------------------------------------------------------------------
  logic signed [16:0] t_sum;
  logic signed [16:0] r_shift;
  logic        [7:0]  q_data;
  logic               q_sat;

  always_comb begin
    t_sum   = {in_data[15], in_data} + RND;
    r_shift = t_sum >>> SHIFT;
    q_data  = r_shift[7:0];
    q_sat   = 1'b0;
    if (r_shift > 17'sd127) begin
      q_data = 8'h7f;
      q_sat  = 1'b1;
    end else if (r_shift < -17'sd128) begin
      q_data = 8'h80;
      q_sat  = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Decimation phase and pipeline register
  // ---------------------------------------------------------------------------
  logic [PW-1:0] phase;
  logic          p_valid;
  logic [7:0]    p_data;
  logic          p_sat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (in_valid) begin
      if (phase == PW'(DECIM - 1)) phase <= '0;
      else                         phase <= phase + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_valid <= 1'b0;
      p_data  <= '0;
      p_sat   <= 1'b0;
    end else begin
      p_valid <= in_valid && (phase == '0);
      p_data  <= q_data;
      p_sat   <= q_sat;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic          full;
  logic          pop;
  logic          wr;
  logic          drop;

  assign out_valid = (level != '0);
  assign full      = (level == LW'(DEPTH));
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr        = p_valid && (!full || pop);
  assign drop      = p_valid && full && !pop;
  assign rd_next   = rd_ptr + 1'b1;

  // Storage carries no reset; only entries below level are ever presented.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= p_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_next;
      case ({wr, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // out_data is a register that follows the head. When the FIFO drains it
  // keeps the last value rather than showing stale storage. The new head
  // after a pop is the next stored entry, unless the FIFO held only the
  // popped entry, in which case it is whatever is written this cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data <= '0;
    end else if (pop && (level > LW'(1))) begin
      out_data <= mem[rd_next];
    end else if (wr && ((level == '0) || (pop && (level == LW'(1))))) begin
      out_data <= p_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky flags (set beats clear)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      if (wr && p_sat)      sat_flag <= 1'b1;
      else if (clear_flags) sat_flag <= 1'b0;

      if (drop)             ovf_flag <= 1'b1;
      else if (clear_flags) ovf_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_requant_decim.sv
module tb_fir_requant_decim;

  localparam int SHIFT = 2;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic [15:0]       in_data;
  logic              out_ready;
  logic              clear_flags;

  logic              a_valid, b_valid;
  logic [7:0]        a_data, b_data;
  logic [2:0]        a_level, b_level;
  logic              a_sat, b_sat, a_ovf, b_ovf;

  fir_requant_decim #(.SHIFT(SHIFT), .DECIM(2), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(a_valid), .out_data(a_data),
    .level(a_level), .sat_flag(a_sat), .ovf_flag(a_ovf),
    .clear_flags(clear_flags));

  fir_requant_decim #(.SHIFT(SHIFT), .DECIM(3), .DEPTH(DEPTH)) u_dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(b_valid), .out_data(b_data),
    .level(b_level), .sat_flag(b_sat), .ovf_flag(b_ovf),
    .clear_flags(clear_flags));

  always #5 clk = ~clk;

  // Observed DUT: the DECIM=2 instance unless sel3 is set.
  bit         sel3 = 1'b0;
  logic       o_valid, o_sat, o_ovf;
  logic [7:0] o_data;
  logic [2:0] o_level;
  assign o_valid = sel3 ? b_valid : a_valid;
  assign o_data  = sel3 ? b_data  : a_data;
  assign o_level = sel3 ? b_level : a_level;
  assign o_sat   = sel3 ? b_sat   : a_sat;
  assign o_ovf   = sel3 ? b_ovf   : a_ovf;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of kept, requantised samples.
  int q[$];
  int got[$];
  int decim_m = 2;
  int m_cnt   = 0;
  bit m_pv    = 0;
  int m_pd    = 0;
  bit m_ps    = 0;
  bit m_sat   = 0;
  bit m_ovf   = 0;
  int m_last  = 0;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Round half up, divide by 2^SHIFT with floor, clamp to 8-bit signed.
  task automatic requant(input int x, output int r, output bit s);
    int dv;
    int t;
    dv = 1 << SHIFT;
    t  = x + ((SHIFT > 0) ? dv / 2 : 0);
    if (t >= 0) r = t / dv;
    else        r = -((-t + dv - 1) / dv);
    s = 1'b0;
    if (r > 127)  begin r = 127;  s = 1'b1; end
    if (r < -128) begin r = -128; s = 1'b1; end
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt = 0; m_pv = 0; m_pd = 0; m_ps = 0;
    m_sat = 0; m_ovf = 0; m_last = 0;
  endtask

  task automatic check_all();
    chk("out_valid", o_valid, (q.size() != 0));
    chk("level", o_level, q.size());
    chk("out_data", $signed(o_data), m_last);
    chk("sat_flag", o_sat, m_sat);
    chk("ovf_flag", o_ovf, m_ovf);
  endtask

  // One clock: drive inputs, advance the model across the edge, compare.
  task automatic step(input bit v, input int d, input bit rdy, input bit clr);
    logic signed [15:0] ds;
    int  r;
    bit  s;
    bit  pop_m;
    bit  full_m;
    ds = d[15:0];
    in_valid = v; in_data = ds; out_ready = rdy; clear_flags = clr;
    #1;
    if (o_valid && rdy) got.push_back(int'($signed(o_data)));
    pop_m  = (q.size() != 0) && rdy;
    full_m = (q.size() == DEPTH);
    if (clr) begin m_sat = 0; m_ovf = 0; end
    if (pop_m) void'(q.pop_front());
    if (m_pv) begin
      if (!full_m || pop_m) begin
        q.push_back(m_pd);
        if (m_ps) m_sat = 1;
      end else begin
        m_ovf = 1;
      end
    end
    requant(int'(ds), r, s);
    m_pv = v && ((m_cnt % decim_m) == 0);
    m_pd = r;
    m_ps = s;
    if (v) m_cnt++;
    @(posedge clk);
    #1;
    if (q.size() != 0) m_last = q[0];
    check_all();
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_out_valid", o_valid, 0);
    chk("rst_level", o_level, 0);
    chk("rst_out_data", o_data, 0);
    chk("rst_sat_flag", o_sat, 0);
    chk("rst_ovf_flag", o_ovf, 0);
    model_reset();
    in_valid = 0; out_ready = 0; clear_flags = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic random_run(input int n);
    int d;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 0) d = int'($urandom_range(0, 65535));
      else                           d = int'($urandom_range(0, 1023)) - 512;
      step($urandom_range(0, 3) != 0, d, $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0);
    end
  endtask

  initial begin
    int vals[];
    int exp_seq[$];
    int r;
    bit s;
    int d;

    reset = 1'b1; in_valid = 0; in_data = '0; out_ready = 0; clear_flags = 0;
    #1;
    chk("init_out_valid", o_valid, 0);
    chk("init_level", o_level, 0);
    chk("init_out_data", o_data, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    step(0, 0, 1, 0);

    // Rounding
    got.delete();
    vals = '{6, 99, -6, 99, 5, 99, -7, 99};
    foreach (vals[i]) step(1, vals[i], 1, 0);
    repeat (3) step(0, 0, 1, 0);
    chk("round_count", got.size(), 4);
    exp_seq = '{2, -1, 1, -2};
    foreach (exp_seq[i]) if (i < got.size()) chk("round_val", got[i], exp_seq[i]);
    chk("round_sat", o_sat, 0);

    // Saturation and flag clear
    got.delete();
    vals = '{1000, 0, -1000, 0};
    foreach (vals[i]) step(1, vals[i], 1, 0);
    repeat (3) step(0, 0, 1, 0);
    chk("sat_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("sat_hi", got[0], 127);
      chk("sat_lo", got[1], -128);
    end
    chk("sat_flag_set", o_sat, 1);
    step(0, 0, 1, 1);
    chk("sat_flag_clr", o_sat, 0);

    // Backpressure overflow
    vals = '{4, 0, 8, 0, 12, 0, 16, 0, 20, 0};
    foreach (vals[i]) step(1, vals[i], 0, 0);
    chk("ovf_level", o_level, 4);
    chk("ovf_flag_set", o_ovf, 1);
    got.delete();
    repeat (5) step(0, 0, 1, 0);
    exp_seq = '{1, 2, 3, 4};
    chk("drain_count", got.size(), 4);
    foreach (exp_seq[i]) if (i < got.size()) chk("drain_val", got[i], exp_seq[i]);
    chk("drain_valid", o_valid, 0);
    chk("drain_level", o_level, 0);
    step(0, 0, 0, 1);

    // Push and pop at full
    do_reset();
    got.delete();
    exp_seq.delete();
    for (int i = 0; i < 8; i++) begin
      d = int'($urandom_range(0, 1023)) - 512;
      if (i % 2 == 0) begin requant(d, r, s); exp_seq.push_back(r); end
      step(1, d, 0, 0);
    end
    chk("full_level", o_level, 4);
    for (int j = 0; j < 20; j++) begin
      d = int'($urandom_range(0, 1023)) - 512;
      if (j % 2 == 0) begin requant(d, r, s); exp_seq.push_back(r); end
      step(1, d, (j % 2) == 1, 0);
      chk("pp_level_ge3", (o_level >= 3), 1);
    end
    repeat (10) step(0, 0, 1, 0);
    chk("pp_ovf", o_ovf, 0);
    chk("pp_count", got.size(), exp_seq.size());
    foreach (exp_seq[i]) if (i < got.size()) chk("pp_order", got[i], exp_seq[i]);

    // Randomised traffic
    random_run(300);

    // Reset mid-operation at level 3, phase 1
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 4 * (i + 1), 0, 0);
    step(0, 0, 0, 0);
    chk("pre_rst_level", o_level, 3);
    do_reset();
    got.delete();
    step(1, 40, 1, 0);
    chk("post_rst_e0_valid", o_valid, 0);
    step(1, 0, 1, 0);
    chk("post_rst_valid", o_valid, 1);
    chk("post_rst_data", $signed(o_data), 10);
    repeat (3) step(0, 0, 1, 0);
    chk("post_rst_count", got.size(), 1);

    // Gaps with DECIM=3
    sel3 = 1'b1;
    decim_m = 3;
    do_reset();
    got.delete();
    vals = '{4, 0, 8, 0, 12, 0, 16};
    foreach (vals[i]) begin
      if (i % 2 == 0) step(1, vals[i], 1, 0);
      else            step(0, int'($urandom_range(0, 65535)), 1, 0);
    end
    repeat (3) step(0, 0, 1, 0);
    chk("d3_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("d3_first", got[0], 1);
      chk("d3_second", got[1], 4);
    end
    random_run(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
